traffic_enable_conditioner: RTL and testbench



---
 rtl/traffic_pkg.sv | 18 +
 rtl/traffic_sync2.sv | 25 ++
 rtl/traffic_enable_conditioner.sv | 135 +++++++++++++
 tb/tb_traffic_enable_conditioner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared enable-conditioner state encoding and default timing constants
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'b00,
        ST_CHK_HI = 2'b01,
        ST_HIGH   = 2'b10,
        ST_CHK_LO = 2'b11
    } traffic_en_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_MIN_HOLD_CYCLES = 64;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_sync2.sv
// rtl/traffic_sync2.sv - generic two-flop synchronizer, reset value 0
module traffic_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    // Two back-to-back flops to resolve metastability on the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/traffic_enable_conditioner.sv
// rtl/traffic_enable_conditioner.sv - sync, debounce and min-hold conditioning of the enable pad; optional TRAFFIC_COND_GLITCH_CNT_EN adds glitch_cnt_o
module traffic_enable_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MIN_HOLD_CYCLES = DEF_MIN_HOLD_CYCLES,
    parameter int CNT_W           = $clog2(max2(DEBOUNCE_CYCLES, MIN_HOLD_CYCLES)) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_enable_i,
    output logic       enable_o,
    output logic       rise_o,
    output logic       fall_o,
    output logic       busy_o,
    output logic       pad_oeb_o
`ifdef TRAFFIC_COND_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD_CYCLES);

    traffic_en_state_e state_q, state_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic              enable_q, enable_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              busy_q, busy_d;
    logic              s2;

    traffic_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_enable_i),
        .q     (s2)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOW;
            dcnt_q   <= '0;
            hold_q   <= '0;
            enable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            hold_q   <= hold_d;
            enable_q <= enable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state: candidates start only once the hold lockout reads zero
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        hold_d  = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (s2 && hold_q == '0) begin
                    state_d = ST_CHK_HI;
                    dcnt_d  = '0;
                end
            end
            ST_CHK_HI: begin
                if (!s2) begin
                    state_d = ST_LOW;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = ST_HIGH;
                    rise_d  = 1'b1;
                    hold_d  = HOLD_LOAD;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!s2 && hold_q == '0) begin
                    state_d = ST_CHK_LO;
                    dcnt_d  = '0;
                end
            end
            ST_CHK_LO: begin
                if (s2) begin
                    state_d = ST_HIGH;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = ST_LOW;
                    fall_d  = 1'b1;
                    hold_d  = HOLD_LOAD;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = ST_LOW;
        endcase
        enable_d = (state_d == ST_HIGH) || (state_d == ST_CHK_LO);
        busy_d   = (state_d == ST_CHK_HI) || (state_d == ST_CHK_LO);
    end

    assign enable_o  = enable_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign busy_o    = busy_q;
    assign pad_oeb_o = 1'b1;

`ifdef TRAFFIC_COND_GLITCH_CNT_EN
    logic       reject;
    logic [7:0] glitch_q;

    assign reject = ((state_q == ST_CHK_HI) && !s2) || ((state_q == ST_CHK_LO) && s2);

    // Saturating count of candidates that fell back to their origin state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= 8'h00;
        end else if (reject && glitch_q != 8'hFF) begin
            glitch_q <= glitch_q + 8'h01;
        end
    end

    assign glitch_cnt_o = glitch_q;
`endif

endmodule

// File: tb/tb_traffic_enable_conditioner.sv
// tb/tb_traffic_enable_conditioner.sv - randomized self-checking bench against a streak-based reference model
module tb_traffic_enable_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw = 1'b0;
    logic enable_o, rise_o, fall_o, busy_o, pad_oeb_o;
`ifdef TRAFFIC_COND_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_o;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // reference model: pipeline of pad samples, streak of new-level samples, lockout time left
    bit m_s1, m_s2, m_en, m_rise, m_fall, m_cand;
    int m_streak, m_hold, m_glitch;

    traffic_enable_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .MIN_HOLD_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_enable_i (raw),
        .enable_o     (enable_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .busy_o       (busy_o),
        .pad_oeb_o    (pad_oeb_o)
`ifdef TRAFFIC_COND_GLITCH_CNT_EN
        ,
        .glitch_cnt_o (glitch_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_en = 0; m_rise = 0; m_fall = 0; m_cand = 0;
        m_streak = 0; m_hold = 0; m_glitch = 0;
    endtask

    task automatic model_step();
        bit s;
        int hold_was;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s = m_s2;
        m_rise = 0;
        m_fall = 0;
        hold_was = m_hold;
        if (m_hold > 0) m_hold--;
        if (m_cand) begin
            if (s == m_en) begin
                m_cand = 0;
                if (m_glitch < 255) m_glitch++;
            end else begin
                m_streak++;
                if (m_streak == DEB) begin
                    m_en = !m_en;
                    if (m_en) m_rise = 1; else m_fall = 1;
                    m_cand = 0;
                    m_hold = HOLD;
                end
            end
        end else if (s != m_en && hold_was == 0) begin
            m_cand = 1;
            m_streak = 0;
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic compare_all();
        check_eq("enable", enable_o, m_en);
        check_eq("rise", rise_o, m_rise);
        check_eq("fall", fall_o, m_fall);
        check_eq("busy", busy_o, m_cand);
        check_eq("pad_oeb", pad_oeb_o, 1);
        check_eq("rise_fall_excl", rise_o & fall_o, 0);
`ifdef TRAFFIC_COND_GLITCH_CNT_EN
        check_eq("glitch_cnt", glitch_cnt_o, m_glitch);
`endif
    endtask

    // one clock: model advances with the DUT edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        model_reset();
        repeat (3) tick();
        rst_n = 1;
    endtask

    int n_rise, n_fall, run;

    initial begin
        model_reset();
        raw = 0;
        rst_n = 0;
        #1;
        check_eq("reset_enable", enable_o, 0);
        check_eq("reset_busy", busy_o, 0);
        check_eq("reset_rise", rise_o, 0);
        check_eq("reset_fall", fall_o, 0);
        repeat (3) tick();
        rst_n = 1;
        repeat (3) tick();

        // accepted rise, then pad drops one cycle later; fall waits for hold expiry
        raw = 1;
        for (int e = 1; e <= 24; e++) begin
            tick();
            check_eq("t1_enable", enable_o, (e >= 7 && e < 20));
            check_eq("t1_rise", rise_o, (e == 7));
            check_eq("t3_fall", fall_o, (e == 20));
            check_eq("t1_busy", busy_o, ((e >= 3 && e <= 6) || (e >= 16 && e <= 19)));
            if (e == 8) raw = 0;
        end

        // short pulse is rejected
        do_reset();
        raw = 1;
        tick(); tick();
        raw = 0;
        for (int e = 3; e <= 15; e++) begin
            tick();
            check_eq("t2_enable", enable_o, 0);
            check_eq("t2_rise", rise_o, 0);
        end
`ifdef TRAFFIC_COND_GLITCH_CNT_EN
        check_eq("t2_glitch", glitch_cnt_o, 1);
`endif

        // reset asserted mid-debounce, pad still high after release
        do_reset();
        raw = 1;
        repeat (5) tick();
        check_eq("t4_busy_pre", busy_o, 1);
        rst_n = 0;
        model_reset();
        #1;
        check_eq("t4_enable_async", enable_o, 0);
        check_eq("t4_busy_async", busy_o, 0);
        check_eq("t4_rise_async", rise_o, 0);
        repeat (2) tick();
        rst_n = 1;
        n_rise = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check_eq("t4_rise_edge", rise_o, (e == 7));
            if (rise_o) n_rise++;
        end
        check_eq("t4_rise_count", n_rise, 1);

        // 300 glitches saturate the reject counter
        do_reset();
        for (int g = 0; g < 300; g++) begin
            raw = 1;
            tick(); tick();
            raw = 0;
            tick(); tick();
            check_eq("t5_enable", enable_o, 0);
        end
        repeat (4) tick();
`ifdef TRAFFIC_COND_GLITCH_CNT_EN
        check_eq("t5_glitch_sat", glitch_cnt_o, 255);
`endif

        // slow toggling: every pad edge gives exactly one pulse
        do_reset();
        n_rise = 0;
        n_fall = 0;
        for (int t = 0; t < 10; t++) begin
            raw = !raw;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (rise_o) n_rise++;
                if (fall_o) n_fall++;
            end
        end
        check_eq("t6_rises", n_rise, 5);
        check_eq("t6_falls", n_fall, 5);

        // random run lengths around the debounce and hold windows
        raw = 0;
        for (int r = 0; r < 200; r++) begin
            raw = $urandom_range(0, 1);
            run = $urandom_range(1, 25);
            repeat (run) tick();
            if (r == 100) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
